// File: rtl/cipher_word_loader_if.sv
// Byte-in / word-out bus of the cipher word loader: control, UART byte side
// and engine word side. master = host/engine side, slave = loader.
interface cipher_word_loader_if #(
    parameter int WORD_W = 32
);
    logic              start;
    logic              abort;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ack;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;
    logic              busy;
    logic              done;
    logic              empty_msg;

    modport master (
        output start, abort, rx_valid, rx_data, word_ready,
        input  rx_ack, word_valid, word_data, busy, done, empty_msg
    );

    modport slave (
        input  start, abort, rx_valid, rx_data, word_ready,
        output rx_ack, word_valid, word_data, busy, done, empty_msg
    );
endinterface

// File: rtl/cipher_word_loader.sv
// Reads a length header from the UART byte stream, assembles that many
// ciphertext words and hands them to the modexp engine through a small FIFO.
module cipher_word_loader #(
    parameter int WORD_W     = 32,
    parameter int LEN_W      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int BIG_ENDIAN = 1
) (
    input logic                 clk,
    input logic                 rst,
    cipher_word_loader_if.slave bus
);
    localparam int WBYTES = WORD_W / 8;
    localparam int HBYTES = LEN_W / 8;
    localparam int BIDX_W = (WBYTES > 1) ? $clog2(WBYTES) : 1;
    localparam int HIDX_W = (HBYTES > 1) ? $clog2(HBYTES) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, HDR, DATA, DRAIN} state_t;

    state_t            state, state_nx;
    logic [LEN_W-1:0]  hdr_q, hdr_nx;
    logic [LEN_W-1:0]  word_cnt;
    logic [HIDX_W-1:0] hdr_idx;
    logic [BIDX_W-1:0] byte_idx;
    logic [WORD_W-1:0] asm_q, asm_nx;
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              done_q, empty_q;
    logic              ack, push, pop, full, flush, done_nx, empty_nx;
    logic              hdr_last, word_last, valid;

    assign valid     = (fifo_cnt != '0);
    assign full      = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign pop       = valid && bus.word_ready;
    assign hdr_last  = (hdr_idx == HIDX_W'(HBYTES - 1));
    assign word_last = (byte_idx == BIDX_W'(WBYTES - 1));

    // Full-width shifts keep the 8-bit-wide configurations free of empty slices
    assign hdr_nx = (BIG_ENDIAN != 0)
                  ? ((hdr_q << 8) | LEN_W'(bus.rx_data))
                  : ((hdr_q >> 8) | (LEN_W'(bus.rx_data) << (LEN_W - 8)));
    assign asm_nx = (BIG_ENDIAN != 0)
                  ? ((asm_q << 8) | WORD_W'(bus.rx_data))
                  : ((asm_q >> 8) | (WORD_W'(bus.rx_data) << (WORD_W - 8)));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ack      = 1'b0;
        push     = 1'b0;
        flush    = 1'b0;
        done_nx  = 1'b0;
        empty_nx = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    ack      = 1'b1;
                    state_nx = HDR;
                end
            end
            HDR: begin
                if (bus.abort) begin
                    flush    = 1'b1;
                    state_nx = IDLE;
                end else if (bus.rx_valid) begin
                    ack = 1'b1;
                    if (hdr_last) begin
                        if (hdr_nx == '0) begin
                            done_nx  = 1'b1;
                            empty_nx = 1'b1;
                            state_nx = IDLE;
                        end else begin
                            state_nx = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (bus.abort) begin
                    flush    = 1'b1;
                    state_nx = IDLE;
                end else if (bus.rx_valid && !full) begin
                    ack = 1'b1;
                    if (word_last) begin
                        push = 1'b1;
                        if ((word_cnt + LEN_W'(1)) == hdr_q) state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bus.abort) begin
                    flush    = 1'b1;
                    state_nx = IDLE;
                end else if (!valid || (fifo_cnt == CNT_W'(1) && pop)) begin
                    // Leave on the final pop so done lands in the cycle after it
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (rst) ack = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_q    <= '0;
            word_cnt <= '0;
            hdr_idx  <= '0;
            byte_idx <= '0;
            asm_q    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            done_q   <= 1'b0;
            empty_q  <= 1'b0;
        end else begin
            done_q  <= done_nx;
            empty_q <= empty_nx;
            if (flush) begin
                byte_idx <= '0;
                hdr_idx  <= '0;
                asm_q    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                case (state)
                    IDLE: if (ack) begin
                        hdr_q    <= '0;
                        hdr_idx  <= '0;
                        byte_idx <= '0;
                        word_cnt <= '0;
                        asm_q    <= '0;
                    end
                    HDR: if (ack) begin
                        hdr_q   <= hdr_nx;
                        hdr_idx <= hdr_last ? '0 : hdr_idx + HIDX_W'(1);
                    end
                    DATA: if (ack) begin
                        asm_q    <= asm_nx;
                        byte_idx <= word_last ? '0 : byte_idx + BIDX_W'(1);
                        if (push) word_cnt <= word_cnt + LEN_W'(1);
                    end
                    default: ;
                endcase
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                    2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= asm_nx;
    end

    assign bus.rx_ack     = ack;
    assign bus.word_valid = valid;
    assign bus.word_data  = valid ? mem[rd_ptr] : '0;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_q;
    assign bus.empty_msg  = empty_q;
endmodule
